// File: rtl/led_ddr_driver.sv
// rtl/led_ddr_driver.sv - multi-channel LED driver with OFF/ON/BLINK/PWM modes and DDR half-cycle outputs
//
// Purpose:
//   Drives LEDS_NR LED channels from one free-running counter. Each channel is
//   OFF, ON, BLINK (follows the counter MSB) or PWM (level in half-cycle
//   units). Configuration writes are buffered in a single pending slot and
//   take effect only at a PWM period boundary, so a channel never glitches
//   mid-period. The DDR outputs (led_d0/led_d1) feed an external ODDR and are
//   forced low until a short warm-up after reset has elapsed.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cfg_valid  in   configuration write request
//   cfg_ready  out  a configuration write can be accepted
//   cfg_ch     in   target channel (out-of-range writes are accepted and dropped)
//   cfg_mode   in   00 OFF, 01 ON, 10 BLINK, 11 PWM
//   cfg_level  in   PWM level in half-cycle units
//   led        out  registered SDR LED drive
//   led_d0     out  rising-half data for ODDR D0
//   led_d1     out  falling-half data for ODDR D1
//   ddr_ok     out  warm-up complete, led_d0/led_d1 valid

module led_ddr_driver #(
  parameter int LEDS_NR = 6,
  parameter int CTR_W   = 25,
  parameter int PWM_W   = 4,
  parameter int WARMUP  = 4,
  localparam int CH_W   = (LEDS_NR > 1) ? $clog2(LEDS_NR) : 1,
  localparam int LVL_W  = PWM_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [1:0]         cfg_mode,
  input  logic [LVL_W-1:0]   cfg_level,
  output logic [LEDS_NR-1:0] led,
  output logic [LEDS_NR-1:0] led_d0,
  output logic [LEDS_NR-1:0] led_d1,
  output logic               ddr_ok
);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_PWM   = 2'b11;

  // Warm-up counter saturates at WARMUP; one extra bit of headroom is not needed.
  localparam int WU_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  logic [CTR_W-1:0] ctr;
  logic [PWM_W-1:0] phase;
  logic             boundary;

  logic [1:0]       act_mode  [LEDS_NR];
  logic [LVL_W-1:0] act_level [LEDS_NR];

  logic             pend_valid;
  logic [CH_W-1:0]  pend_ch;
  logic [1:0]       pend_mode;
  logic [LVL_W-1:0] pend_level;

  logic [WU_W-1:0]  wu_cnt;
  logic [WU_W-1:0]  wu_next;
  logic             ok_next;

  logic             accept;
  logic             in_range;

  logic [LEDS_NR-1:0] v0;
  logic [LEDS_NR-1:0] v1;

  // 2*phase and 2*phase+1 at PWM_W+2 bits so level (PWM_W+1 bits) compares unsigned without overflow.
  logic [PWM_W+1:0] half_even;
  logic [PWM_W+1:0] half_odd;

  assign phase     = ctr[PWM_W-1:0];
  assign boundary  = &phase;
  assign half_even = {1'b0, phase, 1'b0};
  assign half_odd  = {1'b0, phase, 1'b1};

  // The single pending slot is the only back-pressure source.
  assign cfg_ready = ~pend_valid;
  assign accept    = cfg_valid & cfg_ready;
  // Extra bit so LEDS_NR = 2^CH_W does not truncate to zero.
  assign in_range  = ({1'b0, cfg_ch} < (CH_W + 1)'(LEDS_NR));

  assign wu_next = (wu_cnt == WU_W'(WARMUP)) ? wu_cnt : wu_cnt + 1'b1;
  // DDR outputs are gated with the next ddr_ok so data and valid flag appear together.
  assign ok_next = (wu_next == WU_W'(WARMUP));

  always_comb begin
    v0 = '0;
    v1 = '0;
    for (int i = 0; i < LEDS_NR; i++) begin
      case (act_mode[i])
        MODE_OFF: begin
          v0[i] = 1'b0;
          v1[i] = 1'b0;
        end
        MODE_ON: begin
          v0[i] = 1'b1;
          v1[i] = 1'b1;
        end
        MODE_BLINK: begin
          v0[i] = ctr[CTR_W-1];
          v1[i] = ctr[CTR_W-1];
        end
        default: begin
          v0[i] = (half_even < {1'b0, act_level[i]});
          v1[i] = (half_odd  < {1'b0, act_level[i]});
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr        <= '0;
      pend_valid <= 1'b0;
      pend_ch    <= '0;
      pend_mode  <= MODE_OFF;
      pend_level <= '0;
      wu_cnt     <= '0;
      ddr_ok     <= 1'b0;
      led        <= '0;
      led_d0     <= '0;
      led_d1     <= '0;
      for (int i = 0; i < LEDS_NR; i++) begin
        act_mode[i]  <= MODE_OFF;
        act_level[i] <= '0;
      end
    end else begin
      ctr    <= ctr + 1'b1;
      wu_cnt <= wu_next;
      ddr_ok <= ok_next;
      led    <= v0;
      led_d0 <= ok_next ? v0 : '0;
      led_d1 <= ok_next ? v1 : '0;

      // Accept and commit are mutually exclusive because accept needs an empty
      // slot; a write accepted in a boundary cycle therefore waits a full period.
      if (boundary && pend_valid) begin
        for (int i = 0; i < LEDS_NR; i++) begin
          if (pend_ch == CH_W'(i)) begin
            act_mode[i]  <= pend_mode;
            act_level[i] <= pend_level;
          end
        end
        pend_valid <= 1'b0;
      end else if (accept && in_range) begin
        pend_valid <= 1'b1;
        pend_ch    <= cfg_ch;
        pend_mode  <= cfg_mode;
        pend_level <= cfg_level;
      end
    end
  end

endmodule

// File: doc/led_ddr_driver.md
LED_DDR_DRIVER -- requirements
Module: led_ddr_driver

Interface
REQ-001 Parameter LEDS_NR, default 6: number of LED channels, 1..16.
REQ-002 Parameter CTR_W, default 25: free-running counter width, at least PWM_W+2.
REQ-003 Parameter PWM_W, default 4: PWM phase width in cycles; DDR gives PWM_W+1 bits of level resolution.
REQ-004 Parameter WARMUP, default 4: cycles after reset during which DDR outputs are held 0.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 cfg_valid  in  1  configuration write request.
REQ-008 cfg_ready  out  1  module can accept a configuration write.
REQ-009 cfg_ch  in  CH_W (= clog2(LEDS_NR), min 1)  target channel.
REQ-010 cfg_mode  in  2  channel mode: 00 OFF, 01 ON, 10 BLINK, 11 PWM.
REQ-011 cfg_level  in  PWM_W+1  PWM level, in half-cycle units.
REQ-012 led  out  LEDS_NR  registered SDR LED drive.
REQ-013 led_d0  out  LEDS_NR  rising-half data for an external ODDR D0.
REQ-014 led_d1  out  LEDS_NR  falling-half data for an external ODDR D1.
REQ-015 ddr_ok  out  1  warm-up complete; led_d0/led_d1 are valid.

Function
REQ-016 ctr SHALL increment by 1 every cycle, wrapping from 2^CTR_W-1 to 0.
REQ-017 phase SHALL be ctr[PWM_W-1:0]; a period boundary SHALL be the cycle in which phase is all ones.
REQ-018 Per channel, the active mode and level SHALL be held in registers that change only at a period boundary.
REQ-019 A write SHALL be accepted when cfg_valid and cfg_ready are both high.
  - It is stored in a pending register.
  - cfg_ready SHALL drop the next cycle.
REQ-020 The pending write SHALL be committed to the active registers at the next period boundary, and cfg_ready SHALL return high the cycle after commit.
REQ-021 A write accepted in a boundary cycle SHALL commit at the following boundary, not the current one.
REQ-022 A write with cfg_ch >= LEDS_NR SHALL be accepted and discarded; cfg_ready SHALL stay high and no state changes.
REQ-023 Combinational per-channel values v0, v1 SHALL be:
  - OFF: v0=v1=0.
  - ON: v0=v1=1.
  - BLINK: v0=v1=ctr[CTR_W-1].
  - PWM: v0=(2*phase < level), v1=(2*phase+1 < level), compared unsigned at PWM_W+2 bits.
REQ-024 led SHALL equal v0 registered, giving 1 cycle of latency from ctr/active state.
REQ-025 led_d0/led_d1 SHALL equal v0/v1 registered while ddr_ok=1, and 0 while ddr_ok=0.
REQ-026 PWM level 0 SHALL give constant 0; level L SHALL give L high half-cycles per 2^(PWM_W+1) half-cycles.
REQ-027 ddr_ok SHALL rise exactly WARMUP cycles after rst_n deasserts, then stay 1 until reset.

Reset
REQ-028 While rst_n=0, the following SHALL hold their reset values:
  - ctr=0; all modes OFF; all levels 0.
  - No pending write; warm-up count 0.
  - led=0, led_d0=0, led_d1=0, ddr_ok=0, cfg_ready=1.
REQ-029 Reset asserted mid-operation SHALL discard any pending write and restart warm-up.

Verification (LEDS_NR=6, CTR_W=8, PWM_W=4, WARMUP=4)
REQ-030 Release reset -> ddr_ok=0 for 4 cycles, then 1; led_d0/led_d1 stay 0 before that; led=0 throughout.
REQ-031 Write ch2 ON at phase 5 -> cfg_ready=0 next cycle; led[2] rises 2 cycles after the phase-15 cycle; cfg_ready=1 the cycle after commit.
REQ-032 Write ch0 PWM level 7 -> per 16-cycle period:
  - d0 high for phases 0..3, d1 high for phases 0..2.
  - Total 7 high half-cycles.
REQ-033 Write ch1 BLINK -> led[1] follows ctr[7]: 128 cycles high, 128 cycles low, toggling at ctr wrap.
REQ-034 Write with cfg_ch=7 -> cfg_ready stays 1; no output changes.
REQ-035 Accept a write, then pulse rst_n low before the boundary -> after reset, all outputs 0 and the write is never applied.
